// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// riscv_pkg -- ALU op codes, RV32 opcodes and decode record shared with the ALU.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  typedef enum logic [3:0] {
    AluOp_ADD  = 4'd0,
    AluOp_SUB  = 4'd1,
    AluOp_AND  = 4'd2,
    AluOp_OR   = 4'd3,
    AluOp_XOR  = 4'd4,
    AluOp_SLL  = 4'd5,
    AluOp_SRL  = 4'd6,
    AluOp_SRA  = 4'd7,
    AluOp_MUL  = 4'd8,
    AluOp_DIV  = 4'd9,
    AluOp_SLTI = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef struct packed {
    alu_op_e     aluop;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } decoded_t;

  localparam decoded_t DEC_RESET = '{aluop: AluOp_ADD, alu_a: 32'd0, alu_b: 32'd0,
                                     rd: 5'd0, wb_en: 1'b0, illegal: 1'b0};

  // funct3 mapping common to OP and OP-IMM; 011 (unsigned compare) is unsupported
  function automatic alu_op_e base_aluop(input logic [2:0] funct3);
    case (funct3)
      3'b001:  return AluOp_SLL;
      3'b010:  return AluOp_SLTI;
      3'b100:  return AluOp_XOR;
      3'b101:  return AluOp_SRL;
      3'b110:  return AluOp_OR;
      3'b111:  return AluOp_AND;
      default: return AluOp_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
//------------------------------------------------------------------------------
// decode_stage_if -- fetch-side and execute-side handshake bundle of decode_stage.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface decode_stage_if #(
  parameter int XLEN = 32
);
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  alu_op_e         out_aluop;
  logic [XLEN-1:0] out_alu_a;
  logic [XLEN-1:0] out_alu_b;
  logic [4:0]      out_rd;
  logic            out_wb_en;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_aluop, out_alu_a, out_alu_b, out_rd,
           out_wb_en, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, out_aluop, out_alu_a, out_alu_b, out_rd,
           out_wb_en, out_pc, out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/rv_decoder.sv
//------------------------------------------------------------------------------
// rv_decoder -- combinational RV32I ALU-op decode; macro RV_M_EN adds MUL/DIV.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        legal;
  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    legal = 1'b0;
    op    = AluOp_ADD;
    a     = rs1_data;
    b     = rs2_data;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = (funct3 != 3'b011);
          op    = base_aluop(funct3);
        end else if (funct7 == F7_ALT) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          op    = (funct3 == 3'b101) ? AluOp_SRA : AluOp_SUB;
        end
`ifdef RV_M_EN
        else if (funct7 == F7_MULDIV) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b100);
          op    = (funct3 == 3'b100) ? AluOp_DIV : AluOp_MUL;
        end
`endif
      end
      OPC_OP_IMM: begin
        op = base_aluop(funct3);
        b  = imm_i;
        case (funct3)
          3'b001: begin
            legal = (funct7 == F7_BASE);
            b     = shamt;
          end
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            op    = (funct7 == F7_ALT) ? AluOp_SRA : AluOp_SRL;
            b     = shamt;
          end
          3'b011:  legal = 1'b0;
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        a     = 32'd0;
        b     = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a     = pc;
        b     = imm_u;
      end
      default: legal = 1'b0;
    endcase

    // Unsupported encodings collapse to a harmless ADD 0,0 with no writeback
    dec.illegal = !legal;
    dec.aluop   = legal ? op : AluOp_ADD;
    dec.alu_a   = legal ? a : 32'd0;
    dec.alu_b   = legal ? b : 32'd0;
    dec.rd      = instr[11:7];
    dec.wb_en   = legal && (instr[11:7] != 5'd0);
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// decode_stage -- one-entry decode pipeline register around rv_decoder (RV_M_EN).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  decoded_t        dec;
  decoded_t        r_dec;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            load;

  rv_decoder u_decoder (
    .instr    (bus.in_instr),
    .pc       (bus.in_pc),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .dec      (dec)
  );

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dec   <= DEC_RESET;
      r_pc    <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_dec   <= dec;
      r_pc    <= bus.in_pc;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_aluop   = r_dec.aluop;
  assign bus.out_alu_a   = r_dec.alu_a;
  assign bus.out_alu_b   = r_dec.alu_b;
  assign bus.out_rd      = r_dec.rd;
  assign bus.out_wb_en   = r_dec.wb_en;
  assign bus.out_illegal = r_dec.illegal;
  assign bus.out_pc      = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// tb_decode_stage -- directed and random checks of decode_stage against a mnemonic-level model.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
  import riscv_pkg::*;

`ifdef RV_M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // expected contents of the pipeline register
  logic        mv;
  logic        mill;
  logic        mwb;
  logic [3:0]  mop;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [4:0]  mrd;
  logic [31:0] mpc;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) intf ();

  decode_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int code_of(input string m);
    string names [11] = '{"ADD", "SUB", "AND", "OR", "XOR", "SLL", "SRL", "SRA", "MUL", "DIV", "SLTI"};
    for (int i = 0; i < 11; i++) if (names[i] == m) return i;
    return -1;
  endfunction

  // Name the instruction first, then derive operands from its format
  task automatic ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2,
                            output logic ill, output logic [3:0] op,
                            output logic [31:0] a, output logic [31:0] b,
                            output logic wb);
    string base [8] = '{"ADD", "SLL", "SLTI", "", "XOR", "SRL", "OR", "AND"};
    string m    = "";
    string kind = "";
    int    f3   = int'(ins[14:12]);
    int    f7   = int'(ins[31:25]);
    int    opc  = int'(ins[6:0]);
    if (opc == 'h33) begin
      kind = "R";
      if (f7 == 0)                    m = base[f3];
      else if (f7 == 'h20)            m = (f3 == 0) ? "SUB" : (f3 == 5) ? "SRA" : "";
      else if (f7 == 1 && M_EN)       m = (f3 == 0) ? "MUL" : (f3 == 4) ? "DIV" : "";
    end else if (opc == 'h13) begin
      kind = (f3 == 1 || f3 == 5) ? "SH" : "I";
      if (f3 == 1)      m = (f7 == 0) ? "SLL" : "";
      else if (f3 == 5) m = (f7 == 0) ? "SRL" : (f7 == 'h20) ? "SRA" : "";
      else              m = base[f3];
    end else if (opc == 'h37) begin
      kind = "LUI";  m = "ADD";
    end else if (opc == 'h17) begin
      kind = "AUIPC"; m = "ADD";
    end
    if (m == "") begin
      ill = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0; wb = 1'b0;
    end else begin
      ill = 1'b0;
      op  = 4'(code_of(m));
      wb  = (ins[11:7] != 5'd0);
      a   = r1;
      b   = r2;
      if (kind == "I")     b = 32'(signed'(ins[31:20]));
      if (kind == "SH")    b = 32'(ins[24:20]);
      if (kind == "LUI")   begin a = 32'd0; b = ins[31:12] << 12; end
      if (kind == "AUIPC") begin a = pc;    b = ins[31:12] << 12; end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic fl, input logic ordy);
    intf.in_valid  = v;
    intf.in_instr  = ins;
    intf.in_pc     = pc;
    intf.rs1_data  = r1;
    intf.rs2_data  = r2;
    intf.flush     = fl;
    intf.out_ready = ordy;
  endtask

  task automatic tick();
    #1;
    chk("in_ready", intf.in_ready, !mv || intf.out_ready);
    @(posedge clk);
    if (rst) begin
      mv = 0; mill = 0; mwb = 0; mop = 0; ma = 0; mb = 0; mrd = 0; mpc = 0;
    end else if (intf.flush) begin
      mv = 0;
    end else if (intf.in_valid && (!mv || intf.out_ready)) begin
      ref_decode(intf.in_instr, intf.in_pc, intf.rs1_data, intf.rs2_data, mill, mop, ma, mb, mwb);
      mrd = intf.in_instr[11:7];
      mpc = intf.in_pc;
      mv  = 1;
    end else if (intf.out_ready) begin
      mv = 0;
    end
    @(negedge clk);
    chk("out_valid", intf.out_valid, mv);
    chk("out_illegal", intf.out_illegal, mill);
    chk("out_wb_en", intf.out_wb_en, mwb);
    chk("out_aluop", 32'(intf.out_aluop), 32'(mop));
    chk("out_alu_a", intf.out_alu_a, ma);
    chk("out_alu_b", intf.out_alu_b, mb);
    chk("out_rd", 32'(intf.out_rd), 32'(mrd));
    chk("out_pc", intf.out_pc, mpc);
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    mv = 1'bx;
    rst = 1'b1;
    // instruction presented during reset must be dropped
    drive(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b0, 1'b1);
    mv = 0;
    tick();
    tick();
    rst = 1'b0;

    // add x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'h200, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    chk("add_valid", intf.out_valid, 1'b1);
    chk("add_aluop", 32'(intf.out_aluop), 32'd0);
    chk("add_a", intf.out_alu_a, 32'd5);
    chk("add_b", intf.out_alu_b, 32'd7);
    chk("add_rd", 32'(intf.out_rd), 32'd3);
    chk("add_wb", intf.out_wb_en, 1'b1);

    // slti x1,x1,-1
    drive(1'b1, 32'hFFF0A093, 32'h204, 32'd3, 32'd9, 1'b0, 1'b1);
    tick();
    chk("slti_aluop", 32'(intf.out_aluop), 32'd10);
    chk("slti_b", intf.out_alu_b, 32'hFFFFFFFF);
    chk("slti_ill", intf.out_illegal, 1'b0);

    // stall for three cycles with a new instruction waiting
    drive(1'b1, 32'h40208233, 32'h208, 32'd20, 32'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0020C2B3, 32'h20C, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("stall_in_ready", intf.in_ready, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    chk("drain_in_ready", intf.in_ready, 1'b1);

    // flush with an op held and a new instruction offered
    drive(1'b1, 32'h00A00513, 32'h300, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00B00593, 32'h304, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("flush_valid", intf.out_valid, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();

    // mul x3,x1,x2
    drive(1'b1, 32'h022081B3, 32'h400, 32'd6, 32'd7, 1'b0, 1'b1);
    tick();
    chk("mul_aluop", 32'(intf.out_aluop), M_EN ? 32'd8 : 32'd0);
    chk("mul_ill", intf.out_illegal, !M_EN);
    chk("mul_wb", intf.out_wb_en, M_EN);

    // reset in the middle of a stall
    drive(1'b1, 32'h123450B7, 32'h500, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_valid", intf.out_valid, 1'b0);
    chk("rst_pc", intf.out_pc, 32'd0);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: opc = OPC_OP;
        1: opc = OPC_OP_IMM;
        2: opc = OPC_LUI;
        3: opc = OPC_AUIPC;
        default: opc = 7'($urandom());
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom());
      endcase
      drive($urandom_range(0, 3) != 0, {f7, r[24:0]} & 32'hFFFF_FF80 | 32'(opc),
            $urandom(), $urandom(), $urandom(),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
